// File: rtl/conv_sequencer.sv
// Control sequencer for the 3x3 convolution window: pops line-buffer columns, applies stride,
// emits window positions to the MAC. Optional stall counter enabled by CONV_SEQ_PERF_EN.
module conv_sequencer #(
  parameter int BIT_DEPTH = 8,
  parameter int COL_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [COL_W-1:0] img_width,
  input  logic [COL_W-1:0] img_height,
  input  logic [1:0]       stride,
  input  logic             col_valid,
  output logic             col_pop,
  output logic             win_shift,
  output logic             row_adv,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [COL_W-1:0] out_row,
  output logic [COL_W-1:0] out_col,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
`ifdef CONV_SEQ_PERF_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_ROW_END, S_DRAIN, S_DONE} state_t;

  localparam logic [COL_W-1:0] MIN_DIM = COL_W'(3);
  localparam logic [COL_W-1:0] ONE     = COL_W'(1);

  state_t           state_q, state_d;
  logic [COL_W-1:0] width_q, width_d, height_q, height_d;
  logic [1:0]       stride_q, stride_d;
  logic [COL_W-1:0] colcnt_q, colcnt_d, top_q, top_d;
  logic [1:0]       hph_q, hph_d, vph_q, vph_d;
  logic [COL_W-1:0] ocol_q, ocol_d, orow_q, orow_d;
  logic             win_valid_q, win_valid_d;
  logic [COL_W-1:0] out_row_q, out_row_d, out_col_q, out_col_d;
  logic             cfg_err_q, cfg_err_d;

  logic             accept;
  logic [COL_W-1:0] col_next;
  logic [1:0]       stride_in;
  logic             cfg_bad;
  logic             hph_last, vph_last;

  assign accept    = win_valid_q & win_ready;
  assign col_next  = colcnt_q + ONE;
  assign stride_in = (stride == 2'd0) ? 2'd1 : stride;
  // A zero-width pixel bus is treated like an undersized frame.
  assign cfg_bad   = (img_width < MIN_DIM) || (img_height < MIN_DIM) || (BIT_DEPTH < 1);
  assign hph_last  = (hph_q == stride_q - 2'd1);
  assign vph_last  = (vph_q == stride_q - 2'd1);

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    height_d    = height_q;
    stride_d    = stride_q;
    colcnt_d    = colcnt_q;
    top_d       = top_q;
    hph_d       = hph_q;
    vph_d       = vph_q;
    ocol_d      = ocol_q;
    orow_d      = orow_q;
    win_valid_d = accept ? 1'b0 : win_valid_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    cfg_err_d   = cfg_err_q;
    col_pop     = 1'b0;
    row_adv     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          width_d  = img_width;
          height_d = img_height;
          stride_d = stride_in;
          colcnt_d = '0;
          top_d    = '0;
          hph_d    = 2'd0;
          vph_d    = 2'd0;
          ocol_d   = '0;
          orow_d   = '0;
          cfg_err_d = cfg_bad;
          state_d   = cfg_bad ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        col_pop = col_valid & (~win_valid_q | win_ready);
        if (col_pop) begin
          colcnt_d = col_next;
          // Window spans columns col_next-3..col_next-1 once three columns are in.
          if (col_next >= MIN_DIM) begin
            if ((hph_q == 2'd0) && (vph_q == 2'd0)) begin
              win_valid_d = 1'b1;
              out_col_d   = ocol_q;
              out_row_d   = orow_q;
              ocol_d      = ocol_q + ONE;
            end
            hph_d = hph_last ? 2'd0 : hph_q + 2'd1;
          end
          if (col_next == width_q) begin
            state_d = (top_q == height_q - MIN_DIM) ? S_DRAIN : S_ROW_END;
          end
        end
      end
      S_ROW_END: begin
        row_adv  = 1'b1;
        top_d    = top_q + ONE;
        colcnt_d = '0;
        hph_d    = 2'd0;
        ocol_d   = '0;
        vph_d    = vph_last ? 2'd0 : vph_q + 2'd1;
        orow_d   = vph_last ? orow_q + ONE : orow_q;
        state_d  = S_RUN;
      end
      S_DRAIN: begin
        if (!win_valid_q || win_ready) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      width_q     <= '0;
      height_q    <= '0;
      stride_q    <= 2'd0;
      colcnt_q    <= '0;
      top_q       <= '0;
      hph_q       <= 2'd0;
      vph_q       <= 2'd0;
      ocol_q      <= '0;
      orow_q      <= '0;
      win_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      stride_q    <= stride_d;
      colcnt_q    <= colcnt_d;
      top_q       <= top_d;
      hph_q       <= hph_d;
      vph_q       <= vph_d;
      ocol_q      <= ocol_d;
      orow_q      <= orow_d;
      win_valid_q <= win_valid_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign win_shift = col_pop;
  assign win_valid = win_valid_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = (state_q == S_RUN) || (state_q == S_ROW_END) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);

`ifdef CONV_SEQ_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_IDLE) && start) begin
      stall_d = 16'd0;
    end else if (busy && win_valid_q && !win_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= 16'd0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: table of frame configurations with hand-computed window
// counts and coordinates, plus hand-written back-pressure, config-error and mid-frame reset cases.
module tb_conv_sequencer;
  localparam int COL_W = 8;

  logic             clk = 1'b0;
  logic             rst, start, col_valid, win_ready;
  logic [COL_W-1:0] img_width, img_height;
  logic [1:0]       stride;
  logic             col_pop, win_shift, row_adv, win_valid, busy, done, cfg_err;
  logic [COL_W-1:0] out_row, out_col;
`ifdef CONV_SEQ_PERF_EN
  logic [15:0]      stall_cycles;
`endif

  always #5 clk = ~clk;

  conv_sequencer #(.BIT_DEPTH(8), .COL_W(COL_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .img_width(img_width), .img_height(img_height), .stride(stride),
    .col_valid(col_valid), .col_pop(col_pop), .win_shift(win_shift), .row_adv(row_adv),
    .win_valid(win_valid), .win_ready(win_ready), .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef CONV_SEQ_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int w, h, s, vmode, rmode;
    int exp_win, exp_pops, exp_radv, exp_cfg, last_r, last_c;
  } vec_t;

  vec_t vecs[9];

  task automatic run_and_check(input vec_t v);
    int pops, radv, dones, busy_at_done, shift_bad, first_win, third_pop;
    int stall_left, cfg_after, done_cyc, idx;
    int wr[$];
    int wc[$];
    bit finished, stalled;
    pops = 0; radv = 0; dones = 0; busy_at_done = 0; shift_bad = 0;
    first_win = -1; third_pop = -1; done_cyc = -1; cfg_after = -1;
    stall_left = (v.rmode == 1) ? 3 : 0;
    finished = 1'b0;
    @(posedge clk); #1;
    img_width  = COL_W'(v.w);
    img_height = COL_W'(v.h);
    stride     = 2'(v.s);
    start      = 1'b1;
    col_valid  = 1'b1;
    win_ready  = 1'b1;
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (cyc == 0) cfg_after = int'(cfg_err);
      col_valid = (v.vmode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      stalled = 1'b0;
      if (stall_left > 0 && win_valid && out_row == 0 && out_col == 1) begin
        win_ready = 1'b0;
        stall_left--;
        stalled = 1'b1;
      end else begin
        win_ready = 1'b1;
      end
      @(negedge clk);
      if (stalled) begin
        chk("stall_vld", int'(win_valid), 1);
        chk("stall_pop", int'(col_pop), 0);
        chk("stall_col", int'(out_col), 1);
      end
      if (col_pop) begin
        pops++;
        if (pops == 3) third_pop = cyc;
      end
      if (win_shift !== col_pop) shift_bad++;
      if (row_adv) radv++;
      if (win_valid && first_win < 0) first_win = cyc;
      if (win_valid && win_ready) begin
        wr.push_back(int'(out_row));
        wc.push_back(int'(out_col));
      end
      if (done) begin
        dones++;
        if (busy) busy_at_done++;
        done_cyc = cyc;
        finished = 1'b1;
      end
    end
    chk("frame_timeout", int'(finished), 1);
    chk("cfg_err", cfg_after, v.exp_cfg);
    chk("pops", pops, v.exp_pops);
    chk("row_adv", radv, v.exp_radv);
    chk("windows", wr.size(), v.exp_win);
    chk("done_pulses", dones, 1);
    chk("busy_at_done", busy_at_done, 0);
    chk("shift_eq_pop", shift_bad, 0);
    if (v.exp_cfg != 0) chk("cfg_done_cyc", done_cyc, 0);
    else                chk("win_latency", first_win - third_pop, 1);
    if (v.rmode == 1) chk("stall_seen", stall_left, 0);
    idx = 0;
    for (int r = 0; r <= v.last_r; r++) begin
      for (int c = 0; c <= v.last_c; c++) begin
        if (idx < wr.size()) begin
          chk("out_row", wr[idx], r);
          chk("out_col", wc[idx], c);
        end
        idx++;
      end
    end
    @(posedge clk); #1;
    chk("done_one_cycle", int'(done), 0);
    chk("idle_not_busy", int'(busy), 0);
  endtask

  initial begin
    bit seen;
    int late_done, late_busy;
    vecs[0] = '{5, 5, 1, 0, 0, 9, 15, 2, 0, 2, 2};
    vecs[1] = '{5, 5, 2, 0, 0, 4, 15, 2, 0, 1, 1};
    vecs[2] = '{5, 5, 1, 1, 0, 9, 15, 2, 0, 2, 2};
    vecs[3] = '{5, 5, 1, 0, 1, 9, 15, 2, 0, 2, 2};
    vecs[4] = '{2, 5, 1, 0, 0, 0, 0, 0, 1, -1, -1};
    vecs[5] = '{5, 5, 1, 0, 0, 9, 15, 2, 0, 2, 2};
    vecs[6] = '{7, 6, 3, 0, 0, 4, 28, 3, 0, 1, 1};
    vecs[7] = '{4, 3, 0, 0, 0, 2, 4, 0, 0, 0, 1};
    vecs[8] = '{3, 3, 2, 0, 0, 1, 3, 0, 0, 0, 0};

    rst = 1'b1; start = 1'b0; col_valid = 1'b0; win_ready = 1'b0;
    img_width = '0; img_height = '0; stride = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_win_valid", int'(win_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    chk("rst_out_row", int'(out_row), 0);
    chk("rst_out_col", int'(out_col), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_and_check(vecs[i]);

    @(posedge clk); #1;
    img_width = 8'd5; img_height = 8'd5; stride = 2'd1;
    start = 1'b1; col_valid = 1'b1; win_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (row_adv) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("mid_rowadv_seen", int'(seen), 1);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_busy", int'(busy), 1);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_win_valid", int'(win_valid), 0);
    chk("abort_col_pop", int'(col_pop), 0);
    chk("abort_row_adv", int'(row_adv), 0);
    chk("abort_out_row", int'(out_row), 0);
    chk("abort_out_col", int'(out_col), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_cfg_err", int'(cfg_err), 0);
    @(posedge clk); #1;
    chk("rst_beats_start", int'(busy), 0);
    rst = 1'b0; start = 1'b0;
    late_done = 0; late_busy = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) late_done++;
      if (busy) late_busy++;
    end
    chk("no_done_after_abort", late_done, 0);
    chk("idle_after_abort", late_busy, 0);

    run_and_check(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
